// File: rtl/axis_pack_fifo.sv
// Packs PACK_RATIO narrow AXI-Stream beats (LSB lane first) into one wide word and buffers it in a FWFT FIFO.
// Optional status ports (almost_full, max_count) are built only when PACK_FIFO_STATUS_EN is defined.
module axis_pack_fifo #(
   parameter int IN_WIDTH   = 64,
   parameter int PACK_RATIO = 2,
   parameter int FIFO_DEPTH = 32
) (
   input  logic                           aclk,
   input  logic                           aresetn,
   input  logic [IN_WIDTH-1:0]            s_tdata,
   input  logic                           s_tvalid,
   output logic                           s_tready,
   input  logic                           s_tlast,
   output logic [IN_WIDTH*PACK_RATIO-1:0] m_tdata,
   output logic                           m_tvalid,
   input  logic                           m_tready,
   output logic [31:0]                    m_count
`ifdef PACK_FIFO_STATUS_EN
   ,
   output logic                           almost_full,
   output logic [31:0]                    max_count
`endif
);

   localparam int OUT_WIDTH = IN_WIDTH * PACK_RATIO;
   localparam int LANE_W    = (PACK_RATIO > 1) ? $clog2(PACK_RATIO) : 1;
   localparam int PTR_W     = $clog2(FIFO_DEPTH);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK_RATIO - 1);
   localparam logic [31:0]       DEPTH32   = 32'(FIFO_DEPTH);

   logic [LANE_W-1:0]    lane_q, lane_d;
   logic [OUT_WIDTH-1:0] part_q, part_d;
   logic [OUT_WIDTH-1:0] push_word_s;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [31:0]          count_q, count_d;
   logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];

   logic full_s;
   logic push_on_accept_s;
   logic accept_s;
   logic push_s;
   logic pop_s;

   assign full_s           = (count_q == DEPTH32);
   assign push_on_accept_s = (lane_q == LAST_LANE) | s_tlast;
   // Only a word-completing beat can be refused; lanes still filling are always taken.
   assign s_tready         = aresetn & ~(push_on_accept_s & full_s);
   assign accept_s         = s_tvalid & s_tready;
   assign push_s           = accept_s & push_on_accept_s;
   assign pop_s            = (count_q != 32'd0) & m_tready;

   // Partial register is zero after every push, so OR-ing the beat in zero-fills higher lanes.
   assign push_word_s = part_q | (OUT_WIDTH'(s_tdata) << (int'(lane_q) * IN_WIDTH));

   assign m_tdata  = mem_q[rd_ptr_q];
   assign m_tvalid = (count_q != 32'd0);
   assign m_count  = count_q;

   // Next-state for packer lanes, pointers and occupancy.
   always_comb begin
      lane_d   = lane_q;
      part_d   = part_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (accept_s) begin
         if (push_on_accept_s) begin
            lane_d = '0;
            part_d = '0;
         end else begin
            lane_d = lane_q + LANE_W'(1);
            part_d = push_word_s;
         end
      end else begin
         lane_d = lane_q;
         part_d = part_q;
      end
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + 32'd1;
         2'b01:   count_d = count_q - 32'd1;
         default: count_d = count_q;
      endcase
   end

   // Control state registers.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         lane_q   <= '0;
         part_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= 32'd0;
      end else begin
         lane_q   <= lane_d;
         part_q   <= part_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Word storage, intentionally left unreset.
   always_ff @(posedge aclk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= push_word_s;
      end
   end

`ifdef PACK_FIFO_STATUS_EN
   logic        almost_full_q;
   logic [31:0] max_count_q;

   assign almost_full = almost_full_q;
   assign max_count   = max_count_q;

   // Status flags; the high-water mark trails m_count by one cycle.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         almost_full_q <= 1'b0;
         max_count_q   <= 32'd0;
      end else begin
         almost_full_q <= (count_d >= (DEPTH32 - 32'd2));
         if (count_q > max_count_q) begin
            max_count_q <= count_q;
         end else begin
            max_count_q <= max_count_q;
         end
      end
   end
`endif

endmodule

// File: tb/tb_axis_pack_fifo.sv
// Directed self-checking bench for axis_pack_fifo: ratio-2 main instance plus a small ratio-4 instance.
module tb_axis_pack_fifo;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic [63:0]   s_tdata;
   logic          s_tvalid, s_tready, s_tlast;
   logic [127:0]  m_tdata;
   logic          m_tvalid, m_tready;
   logic [31:0]   m_count;
   logic [15:0]   s4_tdata;
   logic          s4_tvalid, s4_tready, s4_tlast;
   logic [63:0]   m4_tdata;
   logic          m4_tvalid, m4_tready;
   logic [31:0]   m4_count;
`ifdef PACK_FIFO_STATUS_EN
   logic          almost_full, almost_full4;
   logic [31:0]   max_count, max_count4;
`endif

   int tests = 0;
   int fails = 0;
   logic [63:0] b;
   int e;

   always #5 aclk = ~aclk;

   axis_pack_fifo #(.IN_WIDTH(64), .PACK_RATIO(2), .FIFO_DEPTH(32)) u_dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_count(m_count)
`ifdef PACK_FIFO_STATUS_EN
      , .almost_full(almost_full), .max_count(max_count)
`endif
   );

   axis_pack_fifo #(.IN_WIDTH(16), .PACK_RATIO(4), .FIFO_DEPTH(4)) u_dut4 (
      .aclk(aclk), .aresetn(aresetn),
      .s_tdata(s4_tdata), .s_tvalid(s4_tvalid), .s_tready(s4_tready), .s_tlast(s4_tlast),
      .m_tdata(m4_tdata), .m_tvalid(m4_tvalid), .m_tready(m4_tready), .m_count(m4_count)
`ifdef PACK_FIFO_STATUS_EN
      , .almost_full(almost_full4), .max_count(max_count4)
`endif
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   initial begin
      aresetn   = 1'b0;
      s_tdata   = 64'd0;  s_tvalid  = 1'b0; s_tlast  = 1'b0; m_tready  = 1'b0;
      s4_tdata  = 16'd0;  s4_tvalid = 1'b0; s4_tlast = 1'b0; m4_tready = 1'b0;
      b = 64'd0;
      e = 0;
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_s_tready", 128'(s_tready), 128'd0);
      chk("rst_m_tvalid", 128'(m_tvalid), 128'd0);
      chk("rst_m_count",  128'(m_count),  128'd0);
`ifdef PACK_FIFO_STATUS_EN
      chk("rst_almost_full", 128'(almost_full), 128'd0);
      chk("rst_max_count",   128'(max_count),   128'd0);
`endif
      aresetn = 1'b1;
      step();

      // Ratio 2: four beats, consumer stalled.
      s_tvalid = 1'b1;
      s_tdata = 64'h1; chk("p2_rdy1", 128'(s_tready), 128'd1); step(); chk("p2_cnt1", 128'(m_count), 128'd0);
      s_tdata = 64'h2; chk("p2_rdy2", 128'(s_tready), 128'd1); step(); chk("p2_cnt2", 128'(m_count), 128'd1);
      s_tdata = 64'h3; chk("p2_rdy3", 128'(s_tready), 128'd1); step(); chk("p2_cnt3", 128'(m_count), 128'd1);
      s_tdata = 64'h4; chk("p2_rdy4", 128'(s_tready), 128'd1); step(); chk("p2_cnt4", 128'(m_count), 128'd2);
      s_tvalid = 1'b0;
      chk("p2_valid", 128'(m_tvalid), 128'd1);
      chk("p2_word0", m_tdata, {64'h2, 64'h1});
      step();
      chk("p2_hold", m_tdata, {64'h2, 64'h1});
      m_tready = 1'b1;
      step(); chk("p2_pop_cnt", 128'(m_count), 128'd1); chk("p2_word1", m_tdata, {64'h4, 64'h3});
      step(); chk("p2_empty_cnt", 128'(m_count), 128'd0); chk("p2_empty_valid", 128'(m_tvalid), 128'd0);
      step(); chk("p2_underflow", 128'(m_count), 128'd0);
      m_tready = 1'b0;

      // Ratio 2: tlast on lane 0 flushes with zeroed upper lane.
      s_tvalid = 1'b1; s_tlast = 1'b1; s_tdata = 64'h55; step();
      s_tlast = 1'b0; s_tdata = 64'h66; step();
      s_tdata = 64'h67; step();
      s_tvalid = 1'b0;
      chk("tl2_cnt", 128'(m_count), 128'd2);
      chk("tl2_word", m_tdata, {64'h0, 64'h55});
      m_tready = 1'b1;
      step(); chk("tl2_next", m_tdata, {64'h67, 64'h66});
      step(); chk("tl2_drained", 128'(m_count), 128'd0);
      m_tready = 1'b0;

      // Ratio 4: three beats ending in tlast, then a full word.
      s4_tvalid = 1'b1;
      s4_tdata = 16'hA; step();
      s4_tdata = 16'hB; step();
      s4_tdata = 16'hC; s4_tlast = 1'b1; step();
      s4_tlast = 1'b0;
      chk("p4_cnt1", 128'(m4_count), 128'd1);
      chk("p4_word0", 128'(m4_tdata), 128'h0000_000C_000B_000A);
      s4_tdata = 16'hD; step();
      s4_tdata = 16'hE; step();
      s4_tdata = 16'hF; step();
      s4_tdata = 16'h10; step();
      s4_tvalid = 1'b0;
      chk("p4_cnt2", 128'(m4_count), 128'd2);
      m4_tready = 1'b1; step(); m4_tready = 1'b0;
      chk("p4_cnt3", 128'(m4_count), 128'd1);
      chk("p4_word1", 128'(m4_tdata), 128'h0010_000F_000E_000D);

      // Ratio 2: fill to full, then back-pressure on odd lanes only.
      s_tvalid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         s_tdata = 64'(i);
         step();
      end
      chk("full_cnt", 128'(m_count), 128'd32);
`ifdef PACK_FIFO_STATUS_EN
      chk("full_almost", 128'(almost_full), 128'd1);
`endif
      s_tdata = 64'd100; chk("full_even_rdy", 128'(s_tready), 128'd1); step();
      s_tdata = 64'd101; chk("full_odd_rdy", 128'(s_tready), 128'd0); step();
      chk("full_cnt_hold", 128'(m_count), 128'd32);
      chk("full_head", m_tdata, {64'd1, 64'd0});
      m_tready = 1'b1;
      chk("full_pop_rdy", 128'(s_tready), 128'd0);
      step();
      m_tready = 1'b0;
      chk("full_cnt31", 128'(m_count), 128'd31);
      chk("full_rdy_after", 128'(s_tready), 128'd1);
      step();
      s_tvalid = 1'b0;
      chk("full_cnt32b", 128'(m_count), 128'd32);
      m_tready = 1'b1;
      for (int i = 1; i < 32; i++) begin
         chk("drain_data", m_tdata, {64'(2 * i + 1), 64'(2 * i)});
         step();
      end
      chk("drain_last", m_tdata, {64'd101, 64'd100});
      step();
      m_tready = 1'b0;
      chk("drain_cnt", 128'(m_count), 128'd0);
      chk("drain_valid", 128'(m_tvalid), 128'd0);
`ifdef PACK_FIFO_STATUS_EN
      chk("drain_almost", 128'(almost_full), 128'd0);
      chk("drain_max", 128'(max_count), 128'd32);
`endif

      // Continuous push and pop holding occupancy at 5 across pointer wraps.
      s_tvalid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         s_tdata = b; b = b + 64'd1;
         step();
      end
      chk("cont_fill", 128'(m_count), 128'd5);
      for (int k = 0; k < 200; k++) begin
         s_tdata = b;
         m_tready = b[0];
         if (b[0]) begin
            chk("cont_order", m_tdata, {64'(2 * e + 1), 64'(2 * e)});
            e++;
         end
         b = b + 64'd1;
         step();
         chk("cont_cnt", 128'(m_count), 128'd5);
      end
      m_tready = 1'b0;

      // Reset mid-word with 7 words stored.
      for (int i = 0; i < 5; i++) begin
         s_tdata = b; b = b + 64'd1;
         step();
      end
      chk("rst7_cnt", 128'(m_count), 128'd7);
      #2;
      aresetn = 1'b0;
      #1;
      chk("rst7_valid", 128'(m_tvalid), 128'd0);
      chk("rst7_zero",  128'(m_count),  128'd0);
      chk("rst7_rdy",   128'(s_tready), 128'd0);
      step();
      aresetn = 1'b1;
      s_tdata = 64'h77; step();
      s_tdata = 64'h88; step();
      s_tvalid = 1'b0;
      chk("post_rst_cnt",  128'(m_count), 128'd1);
      chk("post_rst_word", m_tdata, {64'h88, 64'h77});
      m_tready = 1'b1; step(); m_tready = 1'b0;
      chk("post_rst_drain", 128'(m_count), 128'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
